// File: rtl/bouncing_box_renderer.sv
// Colour stage behind the VGA timing controller: a solid square bouncing on a flat background.
// Optional 1-pixel white screen border is enabled by defining BOUNCE_BORDER_EN.
//
// state | meaning
// FWD   | axis moving right (X) or down (Y)
// REV   | axis moving left (X) or up (Y)
module bouncing_box_renderer #(
  parameter int          SCREEN_W = 800,
  parameter int          SCREEN_H = 600,
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [23:0] BOX_RGB  = 24'hFF0000,
  parameter logic [23:0] BG_RGB   = 24'h000080
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic [11:0] nextX,
  input  logic [11:0] nextY,
  input  logic        blank_in_n,
  input  logic        sync_in_n,
  input  logic        hSync_in_n,
  input  logic        vSync_in_n,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        blank_n,
  output logic        sync_n,
  output logic        hSync_n,
  output logic        vSync_n,
  output logic [11:0] boxX,
  output logic [11:0] boxY
);

  typedef enum logic {FWD, REV} dir_t;

  localparam logic [12:0] MAX_X  = 13'(SCREEN_W - BOX_SIZE);
  localparam logic [12:0] MAX_Y  = 13'(SCREEN_H - BOX_SIZE);
  localparam logic [12:0] SIZE13 = 13'(BOX_SIZE);
  localparam logic [12:0] STEP13 = 13'(STEP);
  localparam logic [11:0] STEP12 = 12'(STEP);

  logic [11:0] x_d1, y_d1;
  logic        blank_d1, sync_d1, hs_d1, vs_d1;
  logic        vs_prev, frame_evt;
  dir_t        dir_x, dir_y;
  logic        hit;
  logic [23:0] pix_rgb;

  // Stage 1: register position and timing.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x_d1     <= '0;
      y_d1     <= '0;
      blank_d1 <= 1'b0;
      sync_d1  <= 1'b1;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
    end else begin
      x_d1     <= nextX;
      y_d1     <= nextY;
      blank_d1 <= blank_in_n;
      sync_d1  <= sync_in_n;
      hs_d1    <= hSync_in_n;
      vs_d1    <= vSync_in_n;
    end
  end

  // Widened by one bit so boxX+BOX_SIZE cannot wrap.
  assign hit = ({1'b0, x_d1} >= {1'b0, boxX}) && ({1'b0, x_d1} < {1'b0, boxX} + SIZE13) &&
               ({1'b0, y_d1} >= {1'b0, boxY}) && ({1'b0, y_d1} < {1'b0, boxY} + SIZE13);

  always_comb begin
    pix_rgb = hit ? BOX_RGB : BG_RGB;
`ifdef BOUNCE_BORDER_EN
    if (x_d1 == 12'd0 || x_d1 == 12'(SCREEN_W - 1) ||
        y_d1 == 12'd0 || y_d1 == 12'(SCREEN_H - 1))
      pix_rgb = 24'hFFFFFF;
`endif
    if (!blank_d1) pix_rgb = '0;
  end

  // Stage 2: registered colour and forwarded timing.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      {Red, Green, Blue} <= '0;
      blank_n            <= 1'b0;
      sync_n             <= 1'b1;
      hSync_n            <= 1'b1;
      vSync_n            <= 1'b1;
    end else begin
      {Red, Green, Blue} <= pix_rgb;
      blank_n            <= blank_d1;
      sync_n             <= sync_d1;
      hSync_n            <= hs_d1;
      vSync_n            <= vs_d1;
    end
  end

  // vs_prev resets low so a vSync already low at release is not taken as an edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_prev   <= 1'b0;
      frame_evt <= 1'b0;
      boxX      <= '0;
      boxY      <= '0;
      dir_x     <= FWD;
      dir_y     <= FWD;
    end else begin
      vs_prev   <= vSync_in_n;
      frame_evt <= vs_prev & ~vSync_in_n & Enable;
      if (frame_evt) begin
        if (dir_x == FWD) begin
          if ({1'b0, boxX} + STEP13 >= MAX_X) begin
            boxX  <= MAX_X[11:0];
            dir_x <= REV;
          end else begin
            boxX <= boxX + STEP12;
          end
        end else begin
          if (boxX <= STEP12) begin
            boxX  <= '0;
            dir_x <= FWD;
          end else begin
            boxX <= boxX - STEP12;
          end
        end
        if (dir_y == FWD) begin
          if ({1'b0, boxY} + STEP13 >= MAX_Y) begin
            boxY  <= MAX_Y[11:0];
            dir_y <= REV;
          end else begin
            boxY <= boxY + STEP12;
          end
        end else begin
          if (boxY <= STEP12) begin
            boxY  <= '0;
            dir_y <= FWD;
          end else begin
            boxY <= boxY - STEP12;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Scoreboard bench for bouncing_box_renderer: driver pushes expected outputs, monitor pops 2 clocks later.
// Reference model tracks the square as position plus signed velocity per frame.
module tb_bouncing_box_renderer;
  localparam int W = 800, H = 600, B = 32, S = 2;

  logic        Clock = 1'b0;
  logic        Reset_n, Enable;
  logic [11:0] nextX, nextY;
  logic        blank_in_n, sync_in_n, hSync_in_n, vSync_in_n;
  logic [7:0]  Red, Green, Blue;
  logic        blank_n, sync_n, hSync_n, vSync_n;
  logic [11:0] boxX, boxY;

  bouncing_box_renderer dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable),
    .nextX(nextX), .nextY(nextY),
    .blank_in_n(blank_in_n), .sync_in_n(sync_in_n), .hSync_in_n(hSync_in_n), .vSync_in_n(vSync_in_n),
    .Red(Red), .Green(Green), .Blue(Blue),
    .blank_n(blank_n), .sync_n(sync_n), .hSync_n(hSync_n), .vSync_n(vSync_n),
    .boxX(boxX), .boxY(boxY)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [23:0] rgb;
    logic [3:0]  tim;
    bit          chk_box;
    int          bx, by;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0, edge_cnt = 0;
  int   mx, my, vx, vy;
  bit   m_prev_vs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int x, input int y, input bit bl);
    if (!bl) return 24'h0;
`ifdef BOUNCE_BORDER_EN
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 24'hFFFFFF;
`endif
    if (x >= mx && x < mx + B && y >= my && y < my + B) return 24'hFF0000;
    return 24'h000080;
  endfunction

  function automatic void model_reset();
    mx = 0; my = 0; vx = S; vy = S; m_prev_vs = 0;
  endfunction

  // Move one axis by its velocity, pinning to the wall and reversing on contact.
  function automatic void move_axis(inout int p, inout int v, input int lim);
    if (v > 0) begin
      if (p + v >= lim) begin p = lim; v = -v; end
      else p = p + v;
    end else begin
      if (p <= -v) begin p = 0; v = -v; end
      else p = p + v;
    end
  endfunction

  task automatic drive(input int x, input int y, input bit bl, input bit sy, input bit hs, input bit vs, input bit cb);
    exp_t e;
    @(negedge Clock);
    nextX = 12'(x); nextY = 12'(y);
    blank_in_n = bl; sync_in_n = sy; hSync_in_n = hs; vSync_in_n = vs;
    if (m_prev_vs && !vs && Enable) begin
      move_axis(mx, vx, W - B);
      move_axis(my, vy, H - B);
    end
    m_prev_vs = vs;
    e.rgb = ref_rgb(x, y, bl);
    e.tim = {bl, sy, hs, vs};
    e.chk_box = cb;
    e.bx = mx; e.by = my;
    e.t = edge_cnt;
    sb.push_back(e);
  endtask

  task automatic pixel();
    int x, y;
    if ($urandom_range(0, 1) == 1) x = mx - 3 + $urandom_range(0, B + 5);
    else x = $urandom_range(0, W - 1);
    if ($urandom_range(0, 1) == 1) y = my - 3 + $urandom_range(0, B + 5);
    else y = $urandom_range(0, H - 1);
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    drive(x, y, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
  endtask

  task automatic frame(input bit en, input int low_cycles, input int npix);
    @(negedge Clock);
    Enable = en;
    for (int i = 0; i < low_cycles; i++) drive(0, 0, 0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < npix; i++) pixel();
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clock);
    #2;
    chk("sb_drain", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every output cycle is valid once an item's latency has elapsed.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].t + 2 <= edge_cnt) begin
        e = sb.pop_front();
        if (e.t + 2 < edge_cnt) begin
          chk("sb_stale", 32'(e.t + 2), 32'(edge_cnt));
        end else begin
          chk("rgb", {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
          chk("timing", {28'h0, blank_n, sync_n, hSync_n, vSync_n}, {28'h0, e.tim});
          if (e.chk_box) chk("box_pos", {8'h0, boxX, boxY}, {8'h0, 12'(e.bx), 12'(e.by)});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Enable = 1'b1;
    nextX = '0; nextY = '0;
    blank_in_n = 1'b0; sync_in_n = 1'b1; hSync_in_n = 1'b1; vSync_in_n = 1'b1;
    model_reset();

    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      nextX = 12'($urandom); nextY = 12'($urandom);
      {blank_in_n, sync_in_n, hSync_in_n, vSync_in_n} = 4'($urandom);
      Enable = 1'($urandom);
      @(posedge Clock); #1;
      chk("reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
      chk("reset_timing", {28'h0, blank_n, sync_n, hSync_n, vSync_n}, 32'h7);
      chk("reset_box", {8'h0, boxX, boxY}, 32'h0);
    end

    @(negedge Clock);
    vSync_in_n = 1'b1; blank_in_n = 1'b0; Enable = 1'b1;
    Reset_n = 1'b1;

    drive(5, 5, 1, 1, 1, 1, 1);
    drive(40, 5, 1, 1, 1, 1, 1);
    drive(5, 5, 0, 1, 1, 1, 1);
    drain();
    chk("dir_box_color_done", 32'(tests > 15), 32'h1);

    for (int i = 0; i < 30; i++)
      drive($urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);

    frame(1'b1, 6, 8);
    drain();
    chk("first_frame_box", {8'h0, boxX, boxY}, {8'h0, 12'd2, 12'd2});

    for (int f = 0; f < 3; f++) frame(1'b0, 3, 4);
    drain();
    chk("frozen_box", {8'h0, boxX, boxY}, {8'h0, 12'd2, 12'd2});

    for (int f = 0; f < 440; f++) frame(($urandom_range(0, 9) != 0), 3, 4);

    drive(mx + 1, my + 1, 1, 1, 1, 1, 1);
    drain();

    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_rgb", {8'h0, Red, Green, Blue}, 32'h0);
    chk("async_reset_timing", {28'h0, blank_n, sync_n, hSync_n, vSync_n}, 32'h7);
    chk("async_reset_box", {8'h0, boxX, boxY}, 32'h0);
    vSync_in_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;
    Enable = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 1, 1);
    frame(1'b1, 3, 6);
    drain();
    chk("post_reset_frame_box", {8'h0, boxX, boxY}, {8'h0, 12'd2, 12'd2});

    drive(0, 300, 1, 1, 1, 1, 1);
    drive(W - 1, 10, 1, 1, 1, 1, 1);
    drive(3, 3, 1, 1, 1, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
